// File: rtl/cdec_pkg.sv
// Shared codes for the CDEC control unit: Xbus endpoints, ALU ops, sequencer
// phases and instruction-field decodes.
package cdec_pkg;

    localparam logic [2:0] XS_PC  = 3'd0;
    localparam logic [2:0] XS_A   = 3'd1;
    localparam logic [2:0] XS_B   = 3'd2;
    localparam logic [2:0] XS_C   = 3'd3;
    localparam logic [2:0] XS_R   = 3'd4;
    localparam logic [2:0] XS_RD  = 3'd5;
    localparam logic [2:0] XS_FLG = 3'd6;
    localparam logic [2:0] XS_FF  = 3'd7;

    localparam logic [2:0] XD_PC  = 3'd0;
    localparam logic [2:0] XD_A   = 3'd1;
    localparam logic [2:0] XD_B   = 3'd2;
    localparam logic [2:0] XD_C   = 3'd3;
    localparam logic [2:0] XD_MAR = 3'd4;
    localparam logic [2:0] XD_WDR = 3'd5;
    localparam logic [2:0] XD_T   = 3'd6;
    localparam logic [2:0] XD_I   = 3'd7;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_INC = 4'd8;

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_HALT  = 2'd2
    } phase_e;

    localparam logic [1:0] SUB_MOV = 2'b00;
    localparam logic [1:0] SUB_LDI = 2'b01;
    localparam logic [1:0] SUB_LD  = 2'b10;
    localparam logic [1:0] SUB_ST  = 2'b11;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_CY     = 3'b011;
    localparam logic [2:0] COND_NCY    = 3'b100;
    localparam logic [2:0] COND_S      = 3'b101;
    localparam logic [2:0] COND_NS     = 3'b110;
    localparam logic [2:0] COND_HALT   = 3'b111;

    typedef enum logic [2:0] {
        IC_MOV  = 3'd0,
        IC_LDI  = 3'd1,
        IC_LD   = 3'd2,
        IC_ST   = 3'd3,
        IC_BR   = 3'd4,
        IC_HALT = 3'd5,
        IC_ALU  = 3'd6
    } insn_class_e;

    function automatic insn_class_e insn_class(input logic [7:0] ir);
        insn_class_e c;
        if (ir[7]) begin
            c = IC_ALU;
        end else if (ir[6]) begin
            c = (ir[5:3] == COND_HALT) ? IC_HALT : IC_BR;
        end else begin
            case (ir[5:4])
                SUB_MOV: c = IC_MOV;
                SUB_LDI: c = IC_LDI;
                SUB_LD:  c = IC_LD;
                default: c = IC_ST;
            endcase
        end
        return c;
    endfunction

    // Index of the final EXEC step; reaching it hands control back to FETCH.
    function automatic logic [1:0] last_exec_step(input insn_class_e c);
        logic [1:0] s;
        case (c)
            IC_MOV:  s = 2'd0;
            IC_LD:   s = 2'd1;
            IC_ALU:  s = 2'd2;
            IC_ST:   s = 2'd2;
            IC_BR:   s = 2'd2;
            IC_LDI:  s = 2'd3;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cdec_controller_if.sv
// Control bundle between the CDEC sequencer (slave side) and the datapath,
// memory and monitor (master side).
interface cdec_controller_if;

    logic       run;
    logic [7:0] I;
    logic [2:0] SZCy;
    logic [2:0] xsrc;
    logic [2:0] xdst;
    logic [3:0] aluop;
    logic       Rwe;
    logic       FLGwe;
    logic       mem_we;
    logic       halted;
    logic [3:0] dbg_state;

    modport master (
        output run, I, SZCy,
        input  xsrc, xdst, aluop, Rwe, FLGwe, mem_we, halted, dbg_state
    );

    modport slave (
        input  run, I, SZCy,
        output xsrc, xdst, aluop, Rwe, FLGwe, mem_we, halted, dbg_state
    );

endinterface

// File: rtl/branch_cond.sv
// Branch condition evaluator: selects and optionally inverts one flag.
// The HALT encoding never reports taken.
module branch_cond
    import cdec_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [2:0] i_szcy,
    output logic       o_taken
);

    logic w_s, w_z, w_cy;

    assign w_s  = i_szcy[2];
    assign w_z  = i_szcy[1];
    assign w_cy = i_szcy[0];

    // Condition decode.
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_ALWAYS: o_taken = 1'b1;
            COND_Z:      o_taken = w_z;
            COND_NZ:     o_taken = ~w_z;
            COND_CY:     o_taken = w_cy;
            COND_NCY:    o_taken = ~w_cy;
            COND_S:      o_taken = w_s;
            COND_NS:     o_taken = ~w_s;
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cdec_controller.sv
// CDEC microprogrammed sequencer: {phase, step} state register with
// combinational decode of one Xbus transfer per cycle.
module cdec_controller
    import cdec_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    cdec_controller_if.slave bus
);

    phase_e      r_phase;
    logic [1:0]  r_step;

    insn_class_e w_class;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic        w_taken;
    logic        w_exec_last;
    logic [2:0]  w_xsrc;
    logic [2:0]  w_xdst;
    logic [3:0]  w_aluop;
    logic        w_rwe;
    logic        w_flgwe;
    logic        w_mem_we;
    logic        w_halted;

    assign w_class     = insn_class(bus.I);
    assign w_rd        = {1'b0, bus.I[3:2]};
    assign w_rs        = {1'b0, bus.I[1:0]};
    assign w_exec_last = (r_step >= last_exec_step(w_class));

    branch_cond u_branch_cond (
        .i_cond  (bus.I[5:3]),
        .i_szcy  (bus.SZCy),
        .o_taken (w_taken)
    );

    // Sequencer state; any unused {phase, step} falls back to FETCH step 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= PH_FETCH;
            r_step  <= 2'd0;
        end else begin
            case (r_phase)
                PH_FETCH: begin
                    case (r_step)
                        2'd0: begin
                            r_step <= bus.run ? 2'd1 : 2'd0;
                        end
                        2'd3: begin
                            r_step  <= 2'd0;
                            r_phase <= (w_class == IC_HALT) ? PH_HALT : PH_EXEC;
                        end
                        default: begin
                            r_step <= r_step + 2'd1;
                        end
                    endcase
                end
                PH_EXEC: begin
                    if (w_exec_last) begin
                        r_phase <= PH_FETCH;
                        r_step  <= 2'd0;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                PH_HALT: begin
                    if (r_step != 2'd0) begin
                        r_phase <= PH_FETCH;
                        r_step  <= 2'd0;
                    end else begin
                        r_step <= 2'd0;
                    end
                end
                default: begin
                    r_phase <= PH_FETCH;
                    r_step  <= 2'd0;
                end
            endcase
        end
    end

    // Transfer decode; anything not listed is the idle transfer PC->T.
    always_comb begin
        w_xsrc   = XS_PC;
        w_xdst   = XD_T;
        w_aluop  = ALU_NOP;
        w_rwe    = 1'b0;
        w_flgwe  = 1'b0;
        w_mem_we = 1'b0;
        w_halted = 1'b0;
        case (r_phase)
            PH_FETCH: begin
                case (r_step)
                    2'd0: w_xdst = bus.run ? XD_MAR : XD_T;
                    2'd1: begin
                        w_xsrc = XS_RD;
                        w_xdst = XD_I;
                    end
                    2'd2: begin
                        w_aluop = ALU_INC;
                        w_rwe   = 1'b1;
                    end
                    default: begin
                        w_xsrc = XS_R;
                        w_xdst = XD_PC;
                    end
                endcase
            end
            PH_EXEC: begin
                case (w_class)
                    IC_MOV: begin
                        case (r_step)
                            2'd0: begin
                                w_xsrc = w_rs;
                                w_xdst = w_rd;
                            end
                            default: ;
                        endcase
                    end
                    IC_ALU: begin
                        case (r_step)
                            2'd0: w_xsrc = w_rs;
                            2'd1: begin
                                w_xsrc  = w_rd;
                                w_aluop = {1'b0, bus.I[6:4]};
                                w_rwe   = 1'b1;
                                w_flgwe = 1'b1;
                            end
                            2'd2: begin
                                w_xsrc = XS_R;
                                w_xdst = w_rd;
                            end
                            default: ;
                        endcase
                    end
                    // PC is bumped past the immediate before rd is written,
                    // so LDI with rd=PC lands on the loaded value.
                    IC_LDI: begin
                        case (r_step)
                            2'd0: w_xdst = XD_MAR;
                            2'd1: begin
                                w_aluop = ALU_INC;
                                w_rwe   = 1'b1;
                            end
                            2'd2: begin
                                w_xsrc = XS_R;
                                w_xdst = XD_PC;
                            end
                            default: begin
                                w_xsrc = XS_RD;
                                w_xdst = w_rd;
                            end
                        endcase
                    end
                    IC_LD: begin
                        case (r_step)
                            2'd0: begin
                                w_xsrc = w_rs;
                                w_xdst = XD_MAR;
                            end
                            2'd1: begin
                                w_xsrc = XS_RD;
                                w_xdst = w_rd;
                            end
                            default: ;
                        endcase
                    end
                    IC_ST: begin
                        case (r_step)
                            2'd0: begin
                                w_xsrc = w_rd;
                                w_xdst = XD_MAR;
                            end
                            2'd1: begin
                                w_xsrc = w_rs;
                                w_xdst = XD_WDR;
                            end
                            2'd2: w_mem_we = 1'b1;
                            default: ;
                        endcase
                    end
                    IC_BR: begin
                        case (r_step)
                            2'd0: w_xdst = XD_MAR;
                            2'd1: begin
                                w_aluop = ALU_INC;
                                w_rwe   = 1'b1;
                            end
                            2'd2: begin
                                w_xsrc = w_taken ? XS_RD : XS_R;
                                w_xdst = XD_PC;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            PH_HALT: begin
                case (r_step)
                    2'd0: w_halted = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.xsrc      = w_xsrc;
    assign bus.xdst      = w_xdst;
    assign bus.aluop     = w_aluop;
    assign bus.Rwe       = w_rwe;
    assign bus.FLGwe     = w_flgwe;
    assign bus.mem_we    = w_mem_we;
    assign bus.halted    = w_halted;
    assign bus.dbg_state = {r_phase, r_step};

endmodule

// File: doc/cdec_controller.md
# cdec_controller

Microprogrammed control unit for the CDEC CPU. It consumes the instruction register `I` and the flag bits `SZCy` from `datapath_core`, and drives that block's control inputs (`xsrc`, `xdst`, `aluop`, `Rwe`, `FLGwe`) one Xbus transfer per cycle. It also drives the memory unit's write strobe. It exposes run/halt status and a state tap for the monitor.

## Interface
Parameters: none (codes live in `cdec_pkg`).
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  1 = allow new instruction fetch; sampled only at FETCH step 0
- `I`  in  8  instruction register contents
- `SZCy`  in  3  flags: [2]=S, [1]=Z, [0]=Cy
- `xsrc`  out  3  Xbus source: 0 PC, 1 A, 2 B, 3 C, 4 R, 5 RD, 6 FLG, 7 FF
- `xdst`  out  3  Xbus destination: 0 PC, 1 A, 2 B, 3 C, 4 MAR, 5 WDR, 6 T, 7 I
- `aluop`  out  4  ALU operation
- `Rwe`  out  1  R register write enable
- `FLGwe`  out  1  flag register write enable
- `mem_we`  out  1  memory write strobe; the memory writes WD at MA on the clock edge
- `halted`  out  1  HALT executed
- `dbg_state`  out  4  {phase, step}

## Operation
- Xbus always writes a destination. The **idle transfer** is xsrc=0, xdst=6 (T), aluop=0, Rwe=FLGwe=mem_we=0.
- State: `phase` ∈ {FETCH=0, EXEC=1, HALT=2} plus a 2-bit `step`. All outputs are combinational decodes of {phase, step, I, SZCy}.
- ISA (in `I`): reg codes 00 PC, 01 A, 10 B, 11 C; rd=I[3:2], rs=I[1:0].
  - I[7]=1: ALU rd←rd op rs, aluop={0,I[6:4]}.
  - I[7:4]=00mm: mm=00 MOV rd←rs; 01 LDI rd←#imm (next byte); 10 LD rd←[rs]; 11 ST [rd]←rs.
  - I[7:6]=01: branch, cond=I[5:3]: 000 always, 001 Z, 010 !Z, 011 Cy, 100 !Cy, 101 S, 110 !S, 111 HALT. Target is the next byte.
- Memory read is combinational from MA. aluop 8 = INC (a+1, b ignored). INC never asserts FLGwe.
- FETCH steps:
  - 0: MAR←PC; if run=0, idle and hold.
  - 1: I←RD.
  - 2: R←INC(PC), xdst=T.
  - 3: PC←R, then go to EXEC step 0, or to HALT if I=01111xxx.
- EXEC steps (the last step returns to FETCH step 0):
  - MOV: 0 rd←rs.
  - ALU:
    - 0: T←rs.
    - 1: Xbus=rd, Rwe=1, FLGwe=1, xdst=T.
    - 2: rd←R.
  - LDI:
    - 0: MAR←PC.
    - 1: R←INC(PC).
    - 2: PC←R.
    - 3: rd←RD (ordering keeps rd=PC correct).
  - LD:
    - 0: MAR←rs.
    - 1: rd←RD.
  - ST:
    - 0: MAR←rd.
    - 1: WDR←rs.
    - 2: mem_we=1 with the idle transfer.
  - Branch:
    - 0: MAR←PC.
    - 1: R←INC(PC).
    - 2: PC←(taken ? RD : R).
- HALT: idle transfer, `halted`=1, held until reset.
- MOV/ALU with rd=PC is legal (register jump).

## Timing
- Reset (asynchronous) forces phase=FETCH, step=0 immediately. Outputs follow combinationally: mem_we=0, halted=0, FLGwe=0, Rwe=0, aluop=0, xsrc=0, xdst=4 if run=1 else 6, dbg_state=0.
- Reset asserted mid-instruction aborts it. A pending ST never strobes mem_we.
- Cycles per instruction: MOV 5, LD 6, ALU 7, ST 7, branch 7, LDI 8. HALT enters the halted state after 4 cycles.
- mem_we is high for exactly one cycle per ST. FLGwe is high for exactly one cycle per ALU instruction.
- The branch condition is evaluated from SZCy during branch step 2 only.
- step wraps only through explicit transitions. Unused {phase, step} encodings go to FETCH step 0.

## Structure
- `cdec_pkg` holds:
  - xsrc/xdst codes
  - ALU_INC constant
  - phase enum
  - instruction class/subop/cond constants
- One sub-module: `branch_cond` (cond, SZCy → taken).

## Test plan
- **Reset then run=1, I held 8'h06:** 4 fetch cycles give (xsrc,xdst) = (0,4), (5,7), (0,6) with Rwe=1 and aluop=8, then (4,0). The EXEC cycle gives (2,1), then the sequence returns to FETCH step 0.
- **I=8'hA7:**
  - EXEC step 0: (3,6).
  - Step 1: (1,6) with aluop=2, Rwe=1, FLGwe=1.
  - Step 2: (4,1).
  - Total 7 cycles.
- **I=8'h48:** with SZCy=3'b010, branch step 2 gives (5,0). With SZCy=3'b000 it gives (4,0).
- **I=8'h3B:**
  - Step 0: (2,4).
  - Step 1: (3,5).
  - Step 2: mem_we=1 for exactly one cycle.
  - Asserting reset during step 2 drops mem_we the same cycle.
- **I=8'h78:** after fetch, halted=1 and the idle transfer persists for 20+ cycles. Reset clears halted asynchronously.
- **run=0 after reset:** idle transfer and dbg_state=0 persist. Raising run starts fetch (xdst=4) in the same cycle.
